// File: rtl/mem_responder.sv
// mem_responder: word-organised memory behind a valid/ready request/response port.
// One transaction in flight; LATENCY wait states between acceptance and response.
// Optional build macro MEM_RESP_ERR_EN enables the misalignment / out-of-range checks
// (rsp_err); without it addresses are forced to word alignment and the index wraps
// modulo DEPTH, which must then be a power of two.
module mem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   input  logic [3:0]        req_be,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            r_state;
   state_e            w_state_next;

   // Latched request and wait-state counter
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata;

   // Registered response fields, held stable for the whole RESP phase
   logic [31:0]       r_rdata;
   logic              r_err;

   // Storage is deliberately not reset
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_commit;
   logic [ADDR_W-1:0] w_addr;
   logic              w_we;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [IDX_W-1:0]  w_index;
   logic              w_err;

   assign w_accept = (r_state == StIdle) && req_valid;

   // The commit/capture edge is the one entering RESP. With LATENCY = 0 that is the
   // acceptance edge itself, so the live request must be used while still in IDLE.
   assign w_addr  = (r_state == StIdle) ? req_addr  : r_addr;
   assign w_we    = (r_state == StIdle) ? req_we    : r_we;
   assign w_be    = (r_state == StIdle) ? req_be    : r_be;
   assign w_wdata = (r_state == StIdle) ? req_wdata : r_wdata;

`ifdef MEM_RESP_ERR_EN
   logic [ADDR_W-3:0] w_index_full;

   assign w_index_full = w_addr[ADDR_W-1:2];
   // Widen both sides so the range check is exact for any DEPTH / ADDR_W pairing
   assign w_err   = (w_addr[1:0] != 2'b00) || (64'(w_index_full) >= 64'(DEPTH));
   assign w_index = w_index_full[IDX_W-1:0];
`else
   logic w_unused_addr;

   // Byte offset and bits above the index are ignored: aligned, wrapping access
   assign w_unused_addr = ^{w_addr[ADDR_W-1:IDX_W+2], w_addr[1:0]};
   assign w_err         = 1'b0;
   assign w_index       = w_addr[IDX_W+1:2];
`endif

   assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

   // Gated by reset_n so a reset coinciding with the commit edge drops the write
   assign w_commit = reset_n && w_enter_resp && w_we && !w_err;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_next = (LATENCY == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            if (r_cnt == 4'd1) begin
               w_state_next = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Output logic: handshake flags depend on state only
   always_comb begin
      req_ready = (r_state == StIdle);
      rsp_valid = (r_state == StResp);
      rsp_rdata = r_rdata;
      rsp_err   = r_err;
   end

   // Request latch, wait counter and response capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= 4'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_be    <= req_be;
            r_wdata <= req_wdata;
         end

         if (w_accept) begin
            r_cnt <= 4'(LATENCY);
         end else if (r_state == StWait) begin
            r_cnt <= r_cnt - 4'd1;
         end else begin
            r_cnt <= 4'd0;
         end

         if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_index];
         end else if ((r_state == StResp) && rsp_ready) begin
            // Return the response fields to their idle value once consumed
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
         end
      end
   end

   // Byte-lane write into storage on the edge entering RESP
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
